// File: rtl/imem_pkg.sv
// Shared definitions for the instruction memory byte-stream loader.
package imem_pkg;

  localparam int IMEM_DATA_W = 16;
  localparam int IMEM_ADDR_W = 4;
  localparam int IMEM_DEPTH  = 16;

  localparam logic [7:0] CSUM_INIT = 8'h00;

  typedef enum logic [2:0] {
    IDLE,
    COUNT,
    HI,
    LO,
    CSUM,
    DONE,
    ERR
  } loader_state_e;

endpackage

// File: rtl/imem_loader_if.sv
// Byte-stream input handshake plus instruction memory write port.
// The loader uses the master modport; the byte source / memory side uses slave.
interface imem_loader_if
  import imem_pkg::*;
#(
  parameter int ADDR_W = IMEM_ADDR_W,
  parameter int DATA_W = IMEM_DATA_W
);

  logic [7:0]        in_data;
  logic              in_valid;
  logic              in_ready;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_waddr;
  logic [DATA_W-1:0] imem_wdata;

  modport master (
    input  in_data, in_valid,
    output in_ready, imem_we, imem_waddr, imem_wdata
  );

  modport slave (
    output in_data, in_valid,
    input  in_ready, imem_we, imem_waddr, imem_wdata
  );

endinterface

// File: rtl/imem_loader_timeout.sv
// Inter-byte timeout counter; only instantiated when IMEM_LOADER_TIMEOUT_EN is defined.
// Counts cycles spent waiting for a byte and flags expiry at TIMEOUT_CYCLES.
module imem_loader_timeout #(
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic active,
  input  logic clear,
  output logic expired
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT_CYCLES);

  logic [CW-1:0] cnt_q, cnt_d;

  // Restart on every accepted byte or while not waiting; saturate at the limit.
  always_comb begin
    cnt_d = cnt_q;
    if (clear || !active) begin
      cnt_d = '0;
    end else if (cnt_q != LIMIT) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired = active && (cnt_q == LIMIT);

endmodule

// File: rtl/imem_loader.sv
// Byte-stream program loader: receives count, 2N data bytes and an XOR
// checksum, packs byte pairs into words written to instruction memory from
// address 0, and holds the CPU while loading (and after a failed load).
// Optional inter-byte timeout enabled by defining IMEM_LOADER_TIMEOUT_EN.
module imem_loader
  import imem_pkg::*;
#(
  parameter int DATA_W         = IMEM_DATA_W,
  parameter int ADDR_W         = IMEM_ADDR_W,
  parameter int DEPTH          = IMEM_DEPTH,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  imem_loader_if.master       bus,
  output logic                cpu_hold,
  output logic                done,
  output logic                err,
  output logic [ADDR_W:0]     words_loaded
);

  if (DATA_W != 16 || TIMEOUT_CYCLES < 1) begin : g_bad_param
    $error("imem_loader: DATA_W must be 16 and TIMEOUT_CYCLES positive");
  end

  localparam logic [7:0] DEPTH_B = 8'(DEPTH);

  loader_state_e     state_q, state_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic [7:0]        hi_q, hi_d;
  logic [7:0]        csum_q, csum_d;
  logic [ADDR_W:0]   words_loaded_q, words_loaded_d;
  logic              imem_we_q, imem_we_d;
  logic [ADDR_W-1:0] imem_waddr_q, imem_waddr_d;
  logic [DATA_W-1:0] imem_wdata_q, imem_wdata_d;
  logic              in_ready_q, in_ready_d;
  logic              cpu_hold_q, cpu_hold_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic              accept;
  logic              timeout_hit;

  assign accept = bus.in_valid && in_ready_q;

`ifdef IMEM_LOADER_TIMEOUT_EN
  imem_loader_timeout #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk     (clk),
    .rst_n   (rst_n),
    .active  (in_ready_q),
    .clear   (accept),
    .expired (timeout_hit)
  );
`else
  assign timeout_hit = 1'b0;
`endif

  // Next-state, byte packing, checksum and write-strobe decode.
  always_comb begin
    state_d        = state_q;
    count_d        = count_q;
    hi_d           = hi_q;
    csum_d         = csum_q;
    words_loaded_d = words_loaded_q;
    imem_we_d      = 1'b0;
    imem_waddr_d   = imem_waddr_q;
    imem_wdata_d   = imem_wdata_q;
    cpu_hold_d     = cpu_hold_q;
    done_d         = done_q;
    err_d          = err_q;

    unique case (state_q)
      IDLE, DONE, ERR: begin
        if (start) begin
          state_d        = COUNT;
          words_loaded_d = '0;
          csum_d         = CSUM_INIT;
          done_d         = 1'b0;
          err_d          = 1'b0;
          cpu_hold_d     = 1'b1;
        end
      end
      COUNT: begin
        if (accept) begin
          if (bus.in_data == 8'h00 || bus.in_data > DEPTH_B) begin
            state_d = ERR;
            err_d   = 1'b1;
          end else begin
            count_d = bus.in_data[ADDR_W:0];
            state_d = HI;
          end
        end
      end
      HI: begin
        if (accept) begin
          hi_d    = bus.in_data;
          csum_d  = csum_q ^ bus.in_data;
          state_d = LO;
        end
      end
      LO: begin
        if (accept) begin
          csum_d         = csum_q ^ bus.in_data;
          imem_we_d      = 1'b1;
          imem_waddr_d   = words_loaded_q[ADDR_W-1:0];
          imem_wdata_d   = {hi_q, bus.in_data};
          words_loaded_d = words_loaded_q + 1'b1;
          state_d        = ((words_loaded_q + 1'b1) == count_q) ? CSUM : HI;
        end
      end
      CSUM: begin
        if (accept) begin
          if (bus.in_data == csum_q) begin
            state_d    = DONE;
            done_d     = 1'b1;
            cpu_hold_d = 1'b0;
          end else begin
            state_d = ERR;
            err_d   = 1'b1;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (timeout_hit && !accept) begin
      state_d = ERR;
      err_d   = 1'b1;
    end

    in_ready_d = (state_d == COUNT) || (state_d == HI) ||
                 (state_d == LO) || (state_d == CSUM);
  end

  // State and output registers; reset abandons any load in progress.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      count_q        <= '0;
      hi_q           <= '0;
      csum_q         <= CSUM_INIT;
      words_loaded_q <= '0;
      imem_we_q      <= 1'b0;
      imem_waddr_q   <= '0;
      imem_wdata_q   <= '0;
      in_ready_q     <= 1'b0;
      cpu_hold_q     <= 1'b0;
      done_q         <= 1'b0;
      err_q          <= 1'b0;
    end else begin
      state_q        <= state_d;
      count_q        <= count_d;
      hi_q           <= hi_d;
      csum_q         <= csum_d;
      words_loaded_q <= words_loaded_d;
      imem_we_q      <= imem_we_d;
      imem_waddr_q   <= imem_waddr_d;
      imem_wdata_q   <= imem_wdata_d;
      in_ready_q     <= in_ready_d;
      cpu_hold_q     <= cpu_hold_d;
      done_q         <= done_d;
      err_q          <= err_d;
    end
  end

  assign bus.in_ready   = in_ready_q;
  assign bus.imem_we    = imem_we_q;
  assign bus.imem_waddr = imem_waddr_q;
  assign bus.imem_wdata = imem_wdata_q;
  assign cpu_hold       = cpu_hold_q;
  assign done           = done_q;
  assign err            = err_q;
  assign words_loaded   = words_loaded_q;

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: expected memory writes are queued when
// a frame is driven and popped by a monitor as the loader writes them.
module tb_imem_loader;
  import imem_pkg::*;

`ifdef IMEM_LOADER_TIMEOUT_EN
  localparam int TO_CYCLES = 20;
`else
  localparam int TO_CYCLES = 1000000;
`endif

  logic       clk;
  logic       rst_n;
  logic       start;
  logic       cpu_hold;
  logic       done;
  logic       err;
  logic [4:0] words_loaded;

  int tests_run;
  int tests_failed;

  logic [19:0] exp_q[$];

  imem_loader_if bus ();

  imem_loader #(
    .DATA_W(16), .ADDR_W(4), .DEPTH(16), .TIMEOUT_CYCLES(TO_CYCLES)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .bus          (bus.master),
    .cpu_hold     (cpu_hold),
    .done         (done),
    .err          (err),
    .words_loaded (words_loaded)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Monitor: every write strobe must match the next queued expectation.
  always @(negedge clk) begin
    if (rst_n && bus.imem_we) begin
      tests_run++;
      if (exp_q.size() == 0) begin
        tests_failed++;
        $display("[TB] FAIL unexpected_write: addr=%0h data=%h, none required",
                 bus.imem_waddr, bus.imem_wdata);
      end else begin
        logic [19:0] e;
        e = exp_q.pop_front();
        if ({bus.imem_waddr, bus.imem_wdata} !== e ||
            words_loaded !== {1'b0, e[19:16]} + 5'd1) begin
          tests_failed++;
          $display("[TB] FAIL write: addr=%0h data=%h wl=%0d, required addr=%0h data=%h wl=%0d",
                   bus.imem_waddr, bus.imem_wdata, words_loaded, e[19:16], e[15:0],
                   e[19:16] + 5'd1);
        end
      end
    end
  end

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Present one byte (called at a negedge); returns at the negedge after acceptance.
  task automatic send_byte(input logic [7:0] b, input bit throttle);
    int cyc;
    if (throttle && $urandom_range(1, 0) == 1) begin
      bus.in_valid = 1'b0;
      bus.in_data  = 8'($urandom);
      repeat ($urandom_range(3, 1)) @(negedge clk);
    end
    bus.in_valid = 1'b1;
    bus.in_data  = b;
    cyc = 0;
    while (!bus.in_ready && cyc < 50) begin
      @(negedge clk);
      cyc++;
    end
    if (cyc >= 50) begin
      tests_run++;
      tests_failed++;
      $display("[TB] FAIL in_ready_wait: in_ready=%b, required 1 within 50 cycles", bus.in_ready);
    end
    @(negedge clk);
  endtask

  // Build a frame of n words whose checksum is accumulated from its data bytes.
  function automatic void make_frame(input int n, input bit bad_csum, output logic [7:0] f[$]);
    logic [7:0] x;
    f = {};
    f.push_back(8'(n));
    x = 8'h00;
    for (int i = 0; i < 2 * n; i++) begin
      logic [7:0] b;
      b = 8'((i * 37 + n * 11 + 5) & 8'hFF);
      f.push_back(b);
      x = x ^ b;
    end
    f.push_back(bad_csum ? ~x : x);
  endfunction

  // Queue expected writes, then drive the frame; optional start pulse before byte start_at.
  task automatic run_frame(input logic [7:0] f[$], input bit throttle, input int start_at);
    int n;
    n = int'(f[0]);
    if (n >= 1 && n <= 16) begin
      for (int i = 0; i < n; i++)
        if (2 * i + 2 < f.size())
          exp_q.push_back({4'(i), f[2*i+1], f[2*i+2]});
    end
    pulse_start();
    for (int i = 0; i < f.size(); i++) begin
      if (i == start_at) begin
        bus.in_valid = 1'b0;
        pulse_start();
      end
      send_byte(f[i], throttle);
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic check_result(input string name, input bit exp_done, input int exp_words);
    int cyc;
    cyc = 0;
    while (!(done || err) && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    repeat (2) @(negedge clk);
    tests_run++;
    if ({done, err, cpu_hold, bus.in_ready} !== {exp_done, !exp_done, !exp_done, 1'b0} ||
        words_loaded !== 5'(exp_words) || exp_q.size() != 0) begin
      tests_failed++;
      $display("[TB] FAIL %s: done=%b err=%b hold=%b rdy=%b wl=%0d pending=%0d, required done=%b err=%b hold=%b rdy=0 wl=%0d pending=0",
               name, done, err, cpu_hold, bus.in_ready, words_loaded, exp_q.size(),
               exp_done, !exp_done, !exp_done, exp_words);
    end
    exp_q = {};
  endtask

  task automatic check_reset_values(input string name);
    tests_run++;
    if ({bus.in_ready, bus.imem_we, bus.imem_waddr, bus.imem_wdata, cpu_hold, done, err, words_loaded} !== '0) begin
      tests_failed++;
      $display("[TB] FAIL %s: rdy=%b we=%b addr=%0h data=%h hold=%b done=%b err=%b wl=%0d, required all zero",
               name, bus.in_ready, bus.imem_we, bus.imem_waddr, bus.imem_wdata, cpu_hold, done, err, words_loaded);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    start = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data  = 8'h00;
    repeat (3) @(negedge clk);
    check_reset_values("reset_values");
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check_reset_values("idle_after_reset");
  endtask

  task automatic test_good_load();
    logic [7:0] f[$];
    f = {8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h40};
    exp_q.push_back({4'h0, 16'h1234});
    exp_q.push_back({4'h1, 16'hABCD});
    pulse_start();
    tests_run++;
    if (cpu_hold !== 1'b1 || bus.in_ready !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL start_hold: hold=%b rdy=%b, required 1 1", cpu_hold, bus.in_ready);
    end
    foreach (f[i]) send_byte(f[i], 1'b0);
    bus.in_valid = 1'b0;
    check_result("good_load", 1'b1, 2);
  endtask

  task automatic test_bad_checksum();
    logic [7:0] f[$];
    f = {8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h41};
    run_frame(f, 1'b0, -1);
    check_result("bad_checksum", 1'b0, 2);
  endtask

  task automatic test_count_bounds();
    logic [7:0] f[$];
    pulse_start();
    send_byte(8'h00, 1'b0);
    bus.in_valid = 1'b0;
    tests_run++;
    if (err !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL count_zero_latency: err=%b, required 1", err);
    end
    check_result("count_zero", 1'b0, 0);
    f = {8'h11};
    run_frame(f, 1'b0, -1);
    check_result("count_17", 1'b0, 0);
    make_frame(16, 1'b0, f);
    run_frame(f, 1'b0, -1);
    check_result("count_16_full", 1'b1, 16);
  endtask

  task automatic test_throttled();
    logic [7:0] f[$];
    f = {8'h03, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77};
    run_frame(f, 1'b0, -1);
    check_result("unthrottled_3", 1'b1, 3);
    for (int r = 0; r < 3; r++) begin
      run_frame(f, 1'b1, -1);
      check_result("throttled_3", 1'b1, 3);
    end
    make_frame(5, 1'b1, f);
    run_frame(f, 1'b1, -1);
    check_result("throttled_bad", 1'b0, 5);
  endtask

  task automatic test_reset_restart();
    logic [7:0] f[$];
    exp_q.push_back({4'h0, 16'h1234});
    pulse_start();
    send_byte(8'h02, 1'b0);
    send_byte(8'h12, 1'b0);
    send_byte(8'h34, 1'b0);
    bus.in_valid = 1'b0;
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1 check_reset_values("mid_load_reset");
    tests_run++;
    if (exp_q.size() != 0) begin
      tests_failed++;
      $display("[TB] FAIL pre_reset_write: pending=%0d, required 0", exp_q.size());
      exp_q = {};
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_reset_values("after_mid_reset");
    f = {8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h40};
    run_frame(f, 1'b0, -1);
    check_result("restart_load", 1'b1, 2);
    run_frame(f, 1'b0, 3);
    check_result("start_mid_frame", 1'b1, 2);
  endtask

`ifdef IMEM_LOADER_TIMEOUT_EN
  task automatic test_timeout();
    pulse_start();
    send_byte(8'h01, 1'b0);
    send_byte(8'hAA, 1'b0);
    bus.in_valid = 1'b0;
    repeat (25) @(negedge clk);
    tests_run++;
    if (err !== 1'b1 || cpu_hold !== 1'b1 || done !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL timeout_err: err=%b hold=%b done=%b, required 1 1 0", err, cpu_hold, done);
    end
    pulse_start();
    send_byte(8'h01, 1'b0);
    send_byte(8'hAA, 1'b0);
    bus.in_valid = 1'b0;
    repeat (19) @(negedge clk);
    exp_q.push_back({4'h0, 16'hAABB});
    send_byte(8'hBB, 1'b0);
    send_byte(8'h11, 1'b0);
    bus.in_valid = 1'b0;
    check_result("stall_19_done", 1'b1, 1);
  endtask
`endif

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    test_reset();
    test_good_load();
    test_bad_checksum();
    test_count_bounds();
    test_throttled();
    test_reset_restart();
`ifdef IMEM_LOADER_TIMEOUT_EN
    test_timeout();
`endif
    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
